// File: rtl/video_timing_pkg.sv
// Shared types and elaboration-time helpers for the video timing generator.
// Phases of one raster axis plus constant functions used to size and
// validate the geometry parameters.
package video_timing_pkg;

    // Phase of one axis; the order is the order the raster walks through them.
    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SY  = 2'd2,
        PH_BP  = 2'd3
    } phase_e;

    // Length of a full line or frame from its four phase lengths.
    function automatic int phase_total(input int act, input int fp, input int sy, input int bp);
        return act + fp + sy + bp;
    endfunction

    // Smallest bit width able to represent max_val.
    function automatic int min_width(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((max_val >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis (horizontal or vertical): position counter plus a
// four-phase FSM (ACT -> FP -> SY -> BP). Advances on step, jumps to the
// start of ACT on restart. Reset parks the axis on the last position.
// Outputs:
//   pos   - registered current position
//   phase - phase the axis holds after the coming edge (lets the parent
//           register flags that line up with pos in the same cycle)
//   wrap  - this step leaves BP and returns pos to 0
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int LEN_ACT = 640,
    parameter int LEN_FP  = 16,
    parameter int LEN_SY  = 96,
    parameter int LEN_BP  = 48,
    parameter int POS_W   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             restart,
    output logic [POS_W-1:0] pos,
    output logic [1:0]       phase,
    output logic             wrap
);

    localparam int               TOTAL    = phase_total(LEN_ACT, LEN_FP, LEN_SY, LEN_BP);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] LAST_BP  = POS_W'(LEN_BP - 1);

    phase_e           phase_q, phase_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] cnt_q, cnt_d;

    // Last in-phase count of each phase.
    function automatic logic [POS_W-1:0] last_cnt(input phase_e p);
        case (p)
            PH_ACT:  return POS_W'(LEN_ACT - 1);
            PH_FP:   return POS_W'(LEN_FP - 1);
            PH_SY:   return POS_W'(LEN_SY - 1);
            default: return POS_W'(LEN_BP - 1);
        endcase
    endfunction

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_ACT:  return PH_FP;
            PH_FP:   return PH_SY;
            PH_SY:   return PH_BP;
            default: return PH_ACT;
        endcase
    endfunction

    // Next position, phase and in-phase count; restart overrides stepping.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (which would infer a latch).
        pos_d   = pos_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        if (restart) begin
            pos_d   = '0;
            phase_d = PH_ACT;
            cnt_d   = '0;
        end else if (step) begin
            pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
            if (cnt_q == last_cnt(phase_q)) begin
                cnt_d   = '0;
                phase_d = next_phase(phase_q);
                wrap    = (phase_q == PH_BP);
            end else begin
                cnt_d = cnt_q + POS_W'(1);
            end
        end
    end

    // Axis state register; reset parks on the final position of BP.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!reset) begin
            pos_q   <= LAST_POS;
            phase_q <= PH_BP;
            cnt_q   <= LAST_BP;
        end else begin
            pos_q   <= pos_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pos   = pos_q;
    assign phase = phase_d;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: hsync/vsync/display_on, beam
// position, line/frame start pulses, frame counter and genlock resync.
// All flags are registered from the next position so they match hpos/vpos
// in the same cycle. The raster advances only when pix_en is high.
// Build option: define VT_FRAME_COUNT_EN to keep the frame counter;
// otherwise frame_count is tied to 0 and its register removed.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int POS_W     = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic               resync,
    output logic [POS_W-1:0]   hpos,
    output logic [POS_W-1:0]   vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = phase_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = phase_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);

    // Reject degenerate geometry at elaboration.
    if (H_DISPLAY <= 0 || H_FRONT <= 0 || H_SYNC <= 0 || H_BACK <= 0 ||
        V_DISPLAY <= 0 || V_BOTTOM <= 0 || V_SYNC <= 0 || V_TOP <= 0 ||
        POS_W <= 0 || FRAME_W <= 0) begin : g_bad_zero
        $error("video_timing_gen: all geometry and width parameters must be non-zero");
    end
    if (POS_W < min_width(H_TOTAL - 1) || POS_W < min_width(V_TOTAL - 1)) begin : g_bad_width
        $error("video_timing_gen: POS_W too small for H_TOTAL-1 / V_TOTAL-1");
    end

    logic       pend_q, pend_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_on_q, display_on_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       restart;
    logic       h_wrap, v_wrap, v_step;
    logic [1:0] h_phase_nxt, v_phase_nxt;

    // A resync (live or pending) takes effect on the next enabled cycle.
    assign restart = pix_en & (resync | pend_q);
    assign v_step  = h_wrap & pix_en;

    video_timing_axis #(
        .LEN_ACT (H_DISPLAY),
        .LEN_FP  (H_FRONT),
        .LEN_SY  (H_SYNC),
        .LEN_BP  (H_BACK),
        .POS_W   (POS_W)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .step    (pix_en),
        .restart (restart),
        .pos     (hpos),
        .phase   (h_phase_nxt),
        .wrap    (h_wrap)
    );

    video_timing_axis #(
        .LEN_ACT (V_DISPLAY),
        .LEN_FP  (V_BOTTOM),
        .LEN_SY  (V_SYNC),
        .LEN_BP  (V_TOP),
        .POS_W   (POS_W)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .step    (v_step),
        .restart (restart),
        .pos     (vpos),
        .phase   (v_phase_nxt),
        .wrap    (v_wrap)
    );

    // Flags derived from the phase each axis enters on this edge.
    always_comb begin
        pend_d        = pix_en ? 1'b0 : (pend_q | resync);
        hsync_d       = (h_phase_nxt == PH_SY) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (v_phase_nxt == PH_SY) ? VSYNC_POL : ~VSYNC_POL;
        display_on_d  = (h_phase_nxt == PH_ACT) && (v_phase_nxt == PH_ACT);
        line_start_d  = restart | h_wrap;
        frame_start_d = restart | v_wrap;
    end

    // Output flag and pending-resync registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q        <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VT_FRAME_COUNT_EN
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;

    // Count frames on the same edge that raises frame_start; wraps silently.
    always_comb begin
        frame_count_d = frame_start_d ? frame_count_q + FRAME_W'(1) : frame_count_q;
    end

    // Frame counter register; all-ones at reset so the first frame reads 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_count_q <= '1;
        else        frame_count_q <= frame_count_d;
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen. Two instances share stimulus:
// the default 800x525 raster and a tiny 8x6 raster. Each is compared every
// cycle against an arithmetic raster model (pixel/line counters and
// window tests), plus targeted checks of the documented corner cases.
module tb_video_timing_gen;

`ifdef VT_FRAME_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    typedef struct {
        int hd, hf, hs, hb;
        int vd, vb, vs, vt;
        bit hpol, vpol;
        int fw;
    } geo_t;

    typedef struct {
        int h, v, fc;
        bit pend, ls, fs;
    } mstate_t;

    localparam geo_t G0 = '{hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vb: 10, vs: 2, vt: 33,
                            hpol: 1'b0, vpol: 1'b0, fw: 8};
    localparam geo_t G1 = '{hd: 4, hf: 1, hs: 2, hb: 1, vd: 3, vb: 1, vs: 1, vt: 1,
                            hpol: 1'b1, vpol: 1'b0, fw: 4};

    logic clk, reset, pix_en, resync;

    logic [9:0] d0_hpos, d0_vpos;
    logic       d0_hsync, d0_vsync, d0_display_on, d0_line_start, d0_frame_start;
    logic [7:0] d0_frame_count;

    logic [2:0] d1_hpos, d1_vpos;
    logic       d1_hsync, d1_vsync, d1_display_on, d1_line_start, d1_frame_start;
    logic [3:0] d1_frame_count;

    video_timing_gen u_dut0 (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .resync      (resync),
        .hpos        (d0_hpos),
        .vpos        (d0_vpos),
        .hsync       (d0_hsync),
        .vsync       (d0_vsync),
        .display_on  (d0_display_on),
        .line_start  (d0_line_start),
        .frame_start (d0_frame_start),
        .frame_count (d0_frame_count)
    );

    video_timing_gen #(
        .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_DISPLAY (3), .V_BOTTOM (1), .V_SYNC (1), .V_TOP (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b0), .POS_W (3), .FRAME_W (4)
    ) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .resync      (resync),
        .hpos        (d1_hpos),
        .vpos        (d1_vpos),
        .hsync       (d1_hsync),
        .vsync       (d1_vsync),
        .display_on  (d1_display_on),
        .line_start  (d1_line_start),
        .frame_start (d1_frame_start),
        .frame_count (d1_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc      = 0;
    mstate_t m0, m1;
    bit      track_fs = 1'b0;
    int      n_fs     = 0;
    int      fs_cyc[4];
    int      fs_fc[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference raster model ----------------
    function automatic int h_total(input geo_t g);
        return g.hd + g.hf + g.hs + g.hb;
    endfunction

    function automatic int v_total(input geo_t g);
        return g.vd + g.vb + g.vs + g.vt;
    endfunction

    function automatic mstate_t mreset(input geo_t g);
        mstate_t m;
        m.h = h_total(g) - 1;
        m.v = v_total(g) - 1;
        m.fc = (1 << g.fw) - 1;
        m.pend = 1'b0;
        m.ls = 1'b0;
        m.fs = 1'b0;
        return m;
    endfunction

    function automatic mstate_t mstep(input mstate_t m, input bit pe, input bit rs, input geo_t g);
        mstate_t n;
        n = m;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (!pe) begin
            n.pend = m.pend | rs;
            return n;
        end
        n.pend = 1'b0;
        if (rs || m.pend) begin
            n.h = 0;
            n.v = 0;
        end else begin
            n.h = (m.h + 1) % h_total(g);
            if (n.h == 0) n.v = (m.v + 1) % v_total(g);
        end
        n.ls = (n.h == 0);
        n.fs = (n.h == 0) && (n.v == 0);
        if (n.fs) n.fc = (m.fc + 1) % (1 << g.fw);
        return n;
    endfunction

    function automatic bit exp_hsync(input geo_t g, input int h);
        bit act;
        act = (h >= g.hd + g.hf) && (h < g.hd + g.hf + g.hs);
        return act ? g.hpol : !g.hpol;
    endfunction

    function automatic bit exp_vsync(input geo_t g, input int v);
        bit act;
        act = (v >= g.vd + g.vb) && (v < g.vd + g.vb + g.vs);
        return act ? g.vpol : !g.vpol;
    endfunction

    task automatic compare_outputs(input string who, input geo_t g, input mstate_t m,
                                   input int hp, input int vp, input logic hs, input logic vs,
                                   input logic de, input logic ls, input logic fs, input int fc);
        check({who, " hpos"}, hp, m.h);
        check({who, " vpos"}, vp, m.v);
        check({who, " hsync"}, hs, exp_hsync(g, m.h));
        check({who, " vsync"}, vs, exp_vsync(g, m.v));
        check({who, " display_on"}, de, (m.h < g.hd) && (m.v < g.vd));
        check({who, " line_start"}, ls, m.ls);
        check({who, " frame_start"}, fs, m.fs);
        check({who, " frame_count"}, fc, FC_EN ? m.fc : 0);
    endtask

    task automatic compare_both();
        compare_outputs("d0", G0, m0, int'(d0_hpos), int'(d0_vpos), d0_hsync, d0_vsync,
                        d0_display_on, d0_line_start, d0_frame_start, int'(d0_frame_count));
        compare_outputs("d1", G1, m1, int'(d1_hpos), int'(d1_vpos), d1_hsync, d1_vsync,
                        d1_display_on, d1_line_start, d1_frame_start, int'(d1_frame_count));
    endtask

    // One clock: drive at negedge, model updates at posedge, compare at next negedge.
    task automatic cycle(input bit pe, input bit rs);
        pix_en = pe;
        resync = rs;
        @(posedge clk);
        m0 = mstep(m0, pe, rs, G0);
        m1 = mstep(m1, pe, rs, G1);
        @(negedge clk);
        cyc++;
        if (track_fs && d1_frame_start && n_fs < 4) begin
            fs_cyc[n_fs] = cyc;
            fs_fc[n_fs]  = int'(d1_frame_count);
            n_fs++;
        end
        compare_both();
    endtask

    initial begin
        int low_cnt, first_low, first_off, idle_pulses, fc_exp;

        reset  = 1'b0;
        pix_en = 1'b0;
        resync = 1'b0;
        m0 = mreset(G0);
        m1 = mreset(G1);
        repeat (3) @(negedge clk);

        // Reset state.
        compare_both();
        check("rst hpos", d0_hpos, 799);
        check("rst vpos", d0_vpos, 524);
        check("rst hsync", d0_hsync, 1);
        check("rst vsync", d0_vsync, 1);
        check("rst display_on", d0_display_on, 0);
        check("rst frame_count", d0_frame_count, FC_EN ? 255 : 0);
        check("rst small hsync", d1_hsync, 0);

        // First enabled cycle after release.
        reset    = 1'b1;
        track_fs = 1'b1;
        cycle(1'b1, 1'b0);
        check("first hpos", d0_hpos, 0);
        check("first vpos", d0_vpos, 0);
        check("first frame_start", d0_frame_start, 1);
        check("first line_start", d0_line_start, 1);
        check("first display_on", d0_display_on, 1);
        check("first frame_count", d0_frame_count, 0);
        check("first hsync", d0_hsync, 1);
        check("first vsync", d0_vsync, 1);

        // One full line of the default raster.
        low_cnt = 0;
        first_low = -1;
        first_off = -1;
        for (int i = 1; i < 800; i++) begin
            cycle(1'b1, 1'b0);
            if (!d0_hsync) begin
                low_cnt++;
                if (first_low < 0) first_low = int'(d0_hpos);
            end
            if (!d0_display_on && first_off < 0) first_off = int'(d0_hpos);
        end
        check("hsync low width", low_cnt, 96);
        check("hsync first low hpos", first_low, 656);
        check("display_on first off hpos", first_off, 640);
        cycle(1'b1, 1'b0);
        check("line wrap hpos", d0_hpos, 0);
        check("line wrap vpos", d0_vpos, 1);
        check("line wrap line_start", d0_line_start, 1);
        check("line wrap frame_start", d0_frame_start, 0);
        track_fs = 1'b0;

        // Small raster: frame period and frame_count progression.
        check("small fs events", n_fs, 4);
        for (int i = 1; i < 4; i++) check("small frame period", fs_cyc[i] - fs_cyc[i-1], 48);
        for (int i = 0; i < 3; i++) check("small frame_count step", fs_fc[i], FC_EN ? i : 0);

        // pix_en toggling: no pulses on idle cycles.
        idle_pulses = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
            if (d0_line_start || d0_frame_start || d1_line_start || d1_frame_start) idle_pulses++;
        end
        check("pulses on idle cycles", idle_pulses, 0);

        // Resync requested while idle, applied two cycles later.
        repeat (37) cycle(1'b1, 1'b0);
        fc_exp = (m0.fc + 1) % 256;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("pending resync hpos", d0_hpos, 0);
        check("pending resync vpos", d0_vpos, 0);
        check("pending resync frame_start", d0_frame_start, 1);
        check("pending resync frame_count", d0_frame_count, FC_EN ? fc_exp : 0);

        // Repeated requests while pending collapse into one restart.
        repeat (23) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        check("collapsed resync hpos", d0_hpos, 0);
        cycle(1'b1, 1'b0);
        check("collapsed resync next hpos", d0_hpos, 1);
        check("collapsed resync no 2nd frame", d0_frame_start, 0);

        // Live resync with pix_en high.
        repeat (11) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("live resync hpos", d0_hpos, 0);
        check("live resync frame_start", d0_frame_start, 1);

        // Randomised enable and resync traffic.
        for (int i = 0; i < 20000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
        end

        // Asynchronous reset asserted between clock edges.
        repeat (5) cycle(1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        m0 = mreset(G0);
        m1 = mreset(G1);
        check("async rst hpos", d0_hpos, 799);
        check("async rst vpos", d0_vpos, 524);
        check("async rst display_on", d0_display_on, 0);
        check("async rst hsync", d0_hsync, 1);
        check("async rst frame_count", d0_frame_count, FC_EN ? 255 : 0);
        compare_both();
        @(negedge clk);
        @(negedge clk);
        compare_both();
        reset = 1'b1;

        // Resync coinciding with the natural frame wrap: one increment only.
        cycle(1'b1, 1'b1);
        check("wrap resync hpos", d0_hpos, 0);
        check("wrap resync vpos", d0_vpos, 0);
        check("wrap resync frame_start", d0_frame_start, 1);
        check("wrap resync frame_count", d0_frame_count, 0);
        cycle(1'b1, 1'b0);
        check("after wrap resync hpos", d0_hpos, 1);
        check("after wrap resync frame_count", d0_frame_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
